mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 134 +++++++++++++
 tb/tb_mc_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for a MIPS subset (FETCH/DECODE/EXEC/MEM/WB).
// Define INSTR_COUNT_EN to build the retired-instruction counter behind instr_cnt.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [2:0]  nPC_Sel,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  RegSrc,
  output logic        ALUSrc,
  output logic        ExtOp,
  output logic [2:0]  ALUCtrl,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  state,
  output logic [31:0] instr_cnt
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4;
  localparam logic [2:0] NPC_PC4 = 3'd0, NPC_BR = 3'd1, NPC_J = 3'd2, NPC_JR = 3'd3;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_SHL16 = 3'd3;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] SRC_ALU = 2'd0, SRC_MEM = 2'd1, SRC_PC4 = 2'd2;

  logic [2:0] state_q, state_d;
  logic       ir_w, pc_w, rf_w, mrd, mwr;
  logic       ex_alusrc, ex_extop;
  logic [2:0] ex_aluctrl;

  logic is_r, i_add, i_sub, i_jr, i_ori, i_lui, i_lw, i_sw, i_beq, i_j, i_jal;
  logic i_jump, i_supp;
  assign is_r   = (opcode == 6'h00);
  assign i_add  = is_r && (funct == 6'h20);
  assign i_sub  = is_r && (funct == 6'h22);
  assign i_jr   = is_r && (funct == 6'h08);
  assign i_ori  = (opcode == 6'h0D);
  assign i_lui  = (opcode == 6'h0F);
  assign i_lw   = (opcode == 6'h23);
  assign i_sw   = (opcode == 6'h2B);
  assign i_beq  = (opcode == 6'h04);
  assign i_j    = (opcode == 6'h02);
  assign i_jal  = (opcode == 6'h03);
  assign i_jump = i_j | i_jr | i_jal;
  assign i_supp = i_jump | i_add | i_sub | i_ori | i_lui | i_lw | i_sw | i_beq;

  // ALU/immediate fields set up in EXEC and held through MEM and WB
  always_comb begin
    ex_alusrc  = 1'b0;
    ex_extop   = 1'b0;
    ex_aluctrl = ALU_ADD;
    if (i_sub) ex_aluctrl = ALU_SUB;
    if (i_ori) begin ex_aluctrl = ALU_OR; ex_alusrc = 1'b1; end
    if (i_lui) begin ex_aluctrl = ALU_SHL16; ex_alusrc = 1'b1; end
    if (i_lw | i_sw) begin ex_alusrc = 1'b1; ex_extop = 1'b1; end
    if (i_beq) begin ex_aluctrl = ALU_SUB; ex_extop = 1'b1; end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (i_jump | ~i_supp) ? S_FETCH : S_EXEC;
      S_EXEC:   state_d = i_beq ? S_FETCH : (i_lw | i_sw) ? S_MEM : S_WB;
      S_MEM:    state_d = !mem_ready ? S_MEM : i_sw ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ir_w = 1'b0; pc_w = 1'b0; rf_w = 1'b0; mrd = 1'b0; mwr = 1'b0;
    nPC_Sel = NPC_PC4; RegDst = DST_RT; RegSrc = SRC_ALU;
    ALUSrc = 1'b0; ExtOp = 1'b0; ALUCtrl = ALU_ADD;
    case (state_q)
      S_FETCH: ir_w = 1'b1;
      S_DECODE: begin
        if (i_j) begin pc_w = 1'b1; nPC_Sel = NPC_J; end
        if (i_jr) begin pc_w = 1'b1; nPC_Sel = NPC_JR; end
        if (i_jal) begin
          pc_w = 1'b1; nPC_Sel = NPC_J; rf_w = 1'b1; RegDst = DST_RA; RegSrc = SRC_PC4;
        end
        if (!i_supp) pc_w = 1'b1;
      end
      S_EXEC: begin
        ALUSrc = ex_alusrc; ExtOp = ex_extop; ALUCtrl = ex_aluctrl;
        if (i_beq) begin pc_w = 1'b1; nPC_Sel = zero ? NPC_BR : NPC_PC4; end
      end
      S_MEM: begin
        ALUSrc = ex_alusrc; ExtOp = ex_extop; ALUCtrl = ex_aluctrl;
        mrd  = i_lw;
        mwr  = i_sw;
        pc_w = i_sw & mem_ready;
      end
      S_WB: begin
        ALUSrc = ex_alusrc; ExtOp = ex_extop; ALUCtrl = ex_aluctrl;
        rf_w = 1'b1; pc_w = 1'b1;
        RegDst = (i_add | i_sub) ? DST_RD : DST_RT;
        RegSrc = i_lw ? SRC_MEM : SRC_ALU;
      end
      default: ;
    endcase
  end

  // strobes are masked while reset is high so an abandoned instruction writes nothing
  assign IRWrite  = ir_w & ~reset;
  assign PCWrite  = pc_w & ~reset;
  assign RegWrite = rf_w & ~reset;
  assign MemRead  = mrd & ~reset;
  assign MemWrite = mwr & ~reset;
  assign state    = state_q;

`ifdef INSTR_COUNT_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d = cnt_q + 32'd1;
  always_ff @(posedge clk) begin
    if (reset)        cnt_q <= '0;
    else if (PCWrite) cnt_q <= cnt_d;
  end
  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = '0;
`endif
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboarded bench for mc_controller: per-cycle expected control vectors are queued per instruction.
module tb_mc_controller;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'h00, funct = 6'h00;
  logic IRWrite, PCWrite, RegWrite, ALUSrc, ExtOp, MemRead, MemWrite;
  logic [2:0] nPC_Sel, ALUCtrl, state;
  logic [1:0] RegDst, RegSrc;
  logic [31:0] instr_cnt;

`ifdef INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  mc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite), .nPC_Sel(nPC_Sel),
    .RegWrite(RegWrite), .RegDst(RegDst), .RegSrc(RegSrc), .ALUSrc(ALUSrc),
    .ExtOp(ExtOp), .ALUCtrl(ALUCtrl), .MemRead(MemRead), .MemWrite(MemWrite),
    .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic rst; logic z; logic rdy; logic [19:0] exp; } ent_t;
  ent_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [31:0] ecnt = 32'd0;

  // {state, IRWrite, PCWrite, nPC_Sel, RegWrite, RegDst, RegSrc, ALUSrc, ExtOp, ALUCtrl, MemRead, MemWrite}
  function automatic logic [19:0] ev(input logic [2:0] st, input logic ir, input logic pc,
      input logic [2:0] npc, input logic rw, input logic [1:0] rd, input logic [1:0] rs,
      input logic as, input logic eo, input logic [2:0] ac, input logic mr, input logic mw);
    return {st, ir, pc, npc, rw, rd, rs, as, eo, ac, mr, mw};
  endfunction

  task automatic push(input logic rst, input logic z, input logic rdy, input logic [19:0] exp);
    ent_t e;
    e.rst = rst; e.z = z; e.rdy = rdy; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic push_fd(input logic z, input logic rdy);
    push(1'b0, z, rdy, ev(3'd0,1,0,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0));
    push(1'b0, z, rdy, ev(3'd1,0,0,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0));
  endtask

  task automatic cyc(input ent_t e, output logic [19:0] got, output logic [31:0] cnt);
    reset = e.rst; zero = e.z; mem_ready = e.rdy;
    @(negedge clk);
    got = {state, IRWrite, PCWrite, nPC_Sel, RegWrite, RegDst, RegSrc, ALUSrc, ExtOp,
           ALUCtrl, MemRead, MemWrite};
    cnt = instr_cnt;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    ent_t e; logic [19:0] got; logic [31:0] gc; int i = 0;
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h23;
    @(posedge clk); #1;
    push(1'b1, 1'b1, 1'b1, ev(3'd0,0,0,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0));
    push(1'b1, 1'b0, 1'b1, ev(3'd0,0,0,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); cyc(e, got, gc); i++;
      n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL reset[%0d] ctrl got %h want %h", i, got, e.exp); end
      n_chk++;
      if (gc !== 32'd0) begin n_fail++; $display("FAIL reset[%0d] instr_cnt got %h want 0", i, gc); end
      ecnt = 32'd0;
    end
  endtask

  task automatic test_add();
    ent_t e; logic [19:0] got; logic [31:0] gc; int i = 0;
    opcode = 6'h00; funct = 6'h20;
    push_fd(1'b1, 1'b1);
    push(1'b0, 1'b1, 1'b1, ev(3'd2,0,0,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0));
    push(1'b0, 1'b1, 1'b1, ev(3'd4,0,1,3'd0,1,2'd1,2'd0,0,0,3'd0,0,0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); cyc(e, got, gc); i++;
      n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL add[%0d] ctrl got %h want %h", i, got, e.exp); end
      n_chk++;
      if (gc !== (CNT_EN ? ecnt : 32'd0)) begin n_fail++; $display("FAIL add[%0d] instr_cnt got %h want %h", i, gc, ecnt); end
      ecnt = e.rst ? 32'd0 : ecnt + (e.exp[15] ? 32'd1 : 32'd0);
    end
  endtask

  task automatic test_alu_imm();
    ent_t e; logic [19:0] got; logic [31:0] gc; int i = 0;
    logic [5:0] ops [3];
    ops[0] = 6'h00; ops[1] = 6'h0D; ops[2] = 6'h0F;
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k]; funct = 6'h22;
      push_fd(1'b0, 1'b1);
      case (k)
        0: begin
          push(1'b0, 1'b0, 1'b1, ev(3'd2,0,0,3'd0,0,2'd0,2'd0,0,0,3'd1,0,0));
          push(1'b0, 1'b0, 1'b1, ev(3'd4,0,1,3'd0,1,2'd1,2'd0,0,0,3'd1,0,0));
        end
        1: begin
          push(1'b0, 1'b0, 1'b1, ev(3'd2,0,0,3'd0,0,2'd0,2'd0,1,0,3'd2,0,0));
          push(1'b0, 1'b0, 1'b1, ev(3'd4,0,1,3'd0,1,2'd0,2'd0,1,0,3'd2,0,0));
        end
        default: begin
          push(1'b0, 1'b0, 1'b1, ev(3'd2,0,0,3'd0,0,2'd0,2'd0,1,0,3'd3,0,0));
          push(1'b0, 1'b0, 1'b1, ev(3'd4,0,1,3'd0,1,2'd0,2'd0,1,0,3'd3,0,0));
        end
      endcase
      while (sb.size() > 0) begin
        e = sb.pop_front(); cyc(e, got, gc); i++;
        n_chk++;
        if (got !== e.exp) begin n_fail++; $display("FAIL alu_imm[%0d] ctrl got %h want %h", i, got, e.exp); end
        n_chk++;
        if (gc !== (CNT_EN ? ecnt : 32'd0)) begin n_fail++; $display("FAIL alu_imm[%0d] instr_cnt got %h want %h", i, gc, ecnt); end
        ecnt = e.rst ? 32'd0 : ecnt + (e.exp[15] ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic test_lw_wait();
    ent_t e; logic [19:0] got; logic [31:0] gc; int i = 0;
    opcode = 6'h23; funct = 6'h20;
    push_fd(1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b1, ev(3'd2,0,0,3'd0,0,2'd0,2'd0,1,1,3'd0,0,0));
    for (int k = 0; k < 3; k++)
      push(1'b0, 1'b0, 1'b0, ev(3'd3,0,0,3'd0,0,2'd0,2'd0,1,1,3'd0,1,0));
    push(1'b0, 1'b0, 1'b1, ev(3'd3,0,0,3'd0,0,2'd0,2'd0,1,1,3'd0,1,0));
    push(1'b0, 1'b0, 1'b0, ev(3'd4,0,1,3'd0,1,2'd0,2'd1,1,1,3'd0,0,0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); cyc(e, got, gc); i++;
      n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL lw_wait[%0d] ctrl got %h want %h", i, got, e.exp); end
      n_chk++;
      if (gc !== (CNT_EN ? ecnt : 32'd0)) begin n_fail++; $display("FAIL lw_wait[%0d] instr_cnt got %h want %h", i, gc, ecnt); end
      ecnt = e.rst ? 32'd0 : ecnt + (e.exp[15] ? 32'd1 : 32'd0);
    end
  endtask

  task automatic test_beq();
    ent_t e; logic [19:0] got; logic [31:0] gc; int i = 0;
    opcode = 6'h04; funct = 6'h00;
    push_fd(1'b0, 1'b1);
    push(1'b0, 1'b1, 1'b1, ev(3'd2,0,1,3'd1,0,2'd0,2'd0,0,1,3'd1,0,0));
    push_fd(1'b1, 1'b1);
    push(1'b0, 1'b0, 1'b1, ev(3'd2,0,1,3'd0,0,2'd0,2'd0,0,1,3'd1,0,0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); cyc(e, got, gc); i++;
      n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL beq[%0d] ctrl got %h want %h", i, got, e.exp); end
      n_chk++;
      if (gc !== (CNT_EN ? ecnt : 32'd0)) begin n_fail++; $display("FAIL beq[%0d] instr_cnt got %h want %h", i, gc, ecnt); end
      ecnt = e.rst ? 32'd0 : ecnt + (e.exp[15] ? 32'd1 : 32'd0);
    end
  endtask

  task automatic test_jumps();
    ent_t e; logic [19:0] got; logic [31:0] gc; int i = 0;
    logic [5:0] ops [5]; logic [5:0] fns [5]; logic [19:0] dec [5];
    ops[0] = 6'h02; fns[0] = 6'h08; dec[0] = ev(3'd1,0,1,3'd2,0,2'd0,2'd0,0,0,3'd0,0,0);
    ops[1] = 6'h00; fns[1] = 6'h08; dec[1] = ev(3'd1,0,1,3'd3,0,2'd0,2'd0,0,0,3'd0,0,0);
    ops[2] = 6'h03; fns[2] = 6'h20; dec[2] = ev(3'd1,0,1,3'd2,1,2'd2,2'd2,0,0,3'd0,0,0);
    ops[3] = 6'h3F; fns[3] = 6'h20; dec[3] = ev(3'd1,0,1,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0);
    ops[4] = 6'h00; fns[4] = 6'h3F; dec[4] = ev(3'd1,0,1,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0);
    for (int k = 0; k < 5; k++) begin
      opcode = ops[k]; funct = fns[k];
      push(1'b0, 1'b1, 1'b1, ev(3'd0,1,0,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0));
      push(1'b0, 1'b1, 1'b1, dec[k]);
      while (sb.size() > 0) begin
        e = sb.pop_front(); cyc(e, got, gc); i++;
        n_chk++;
        if (got !== e.exp) begin n_fail++; $display("FAIL jumps[%0d] op %h ctrl got %h want %h", i, opcode, got, e.exp); end
        n_chk++;
        if (gc !== (CNT_EN ? ecnt : 32'd0)) begin n_fail++; $display("FAIL jumps[%0d] instr_cnt got %h want %h", i, gc, ecnt); end
        ecnt = e.rst ? 32'd0 : ecnt + (e.exp[15] ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic test_sw_reset();
    ent_t e; logic [19:0] got; logic [31:0] gc; int i = 0;
    opcode = 6'h2B; funct = 6'h00;
    push_fd(1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b1, ev(3'd2,0,0,3'd0,0,2'd0,2'd0,1,1,3'd0,0,0));
    push(1'b0, 1'b0, 1'b0, ev(3'd3,0,0,3'd0,0,2'd0,2'd0,1,1,3'd0,0,1));
    push(1'b0, 1'b0, 1'b1, ev(3'd3,0,1,3'd0,0,2'd0,2'd0,1,1,3'd0,0,1));
    push_fd(1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b1, ev(3'd2,0,0,3'd0,0,2'd0,2'd0,1,1,3'd0,0,0));
    push(1'b0, 1'b0, 1'b0, ev(3'd3,0,0,3'd0,0,2'd0,2'd0,1,1,3'd0,0,1));
    push(1'b1, 1'b0, 1'b1, ev(3'd3,0,0,3'd0,0,2'd0,2'd0,1,1,3'd0,0,0));
    push(1'b0, 1'b0, 1'b1, ev(3'd0,1,0,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); cyc(e, got, gc); i++;
      n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL sw_reset[%0d] ctrl got %h want %h", i, got, e.exp); end
      n_chk++;
      if (gc !== (CNT_EN ? ecnt : 32'd0)) begin n_fail++; $display("FAIL sw_reset[%0d] instr_cnt got %h want %h", i, gc, ecnt); end
      ecnt = e.rst ? 32'd0 : ecnt + (e.exp[15] ? 32'd1 : 32'd0);
    end
    // finish the DECODE of the in-flight sw so the next test starts at FETCH
    push(1'b0, 1'b0, 1'b1, ev(3'd1,0,0,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0));
    push(1'b0, 1'b0, 1'b1, ev(3'd2,0,0,3'd0,0,2'd0,2'd0,1,1,3'd0,0,0));
    push(1'b0, 1'b0, 1'b1, ev(3'd3,0,1,3'd0,0,2'd0,2'd0,1,1,3'd0,0,1));
    while (sb.size() > 0) begin
      e = sb.pop_front(); cyc(e, got, gc); i++;
      n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL sw_reset[%0d] ctrl got %h want %h", i, got, e.exp); end
      ecnt = e.rst ? 32'd0 : ecnt + (e.exp[15] ? 32'd1 : 32'd0);
    end
  endtask

  task automatic test_counter();
    ent_t e; logic [19:0] got; logic [31:0] gc; int i = 0;
`ifdef INSTR_COUNT_EN
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    ecnt = 32'hFFFF_FFFF;
`endif
    opcode = 6'h02; funct = 6'h00;
    push(1'b0, 1'b0, 1'b0, ev(3'd0,1,0,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0));
    push(1'b0, 1'b0, 1'b0, ev(3'd1,0,1,3'd2,0,2'd0,2'd0,0,0,3'd0,0,0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); cyc(e, got, gc); i++;
      n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL counter[%0d] ctrl got %h want %h", i, got, e.exp); end
      n_chk++;
      if (gc !== (CNT_EN ? ecnt : 32'd0)) begin n_fail++; $display("FAIL counter[%0d] instr_cnt got %h want %h", i, gc, ecnt); end
      ecnt = e.rst ? 32'd0 : ecnt + (e.exp[15] ? 32'd1 : 32'd0);
    end
    opcode = 6'h3F;
    push(1'b0, 1'b0, 1'b1, ev(3'd0,1,0,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0));
    push(1'b0, 1'b0, 1'b1, ev(3'd1,0,1,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0));
    push(1'b0, 1'b0, 1'b1, ev(3'd0,1,0,3'd0,0,2'd0,2'd0,0,0,3'd0,0,0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); cyc(e, got, gc); i++;
      n_chk++;
      if (got !== e.exp) begin n_fail++; $display("FAIL counter[%0d] ctrl got %h want %h", i, got, e.exp); end
      n_chk++;
      if (gc !== (CNT_EN ? ecnt : 32'd0)) begin n_fail++; $display("FAIL counter[%0d] instr_cnt got %h want %h", i, gc, ecnt); end
      ecnt = e.rst ? 32'd0 : ecnt + (e.exp[15] ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_imm();
    test_lw_wait();
    test_beq();
    test_jumps();
    test_sw_reset();
    test_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end
endmodule
